// File: rtl/parity_frame_ctrl.sv
// Two-requester round-robin front end for a serial parity checker: latches a word, shifts it LSB-first on x, strobes done.
// Latency: grant one cycle after the request is sampled, done WIDTH cycles after grant (+1 with PARITY_CHECK_EN).
// Backpressure: requests are level-sampled only in IDLE; a busy frame ignores req/data/exp_par changes.
module parity_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             exp_par0,
    input  logic             exp_par1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             owner,
    output logic             busy,
    output logic             x,
    output logic             z,
    output logic             done,
    output logic             parity,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
`ifdef PARITY_CHECK_EN
        , ST_CHECK = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             par_q, par_d;
    logic             last_owner_q, last_owner_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             x_q, x_d;
    logic             done_q, done_d;
    logic             parity_q, parity_d;
    logic             err_q, err_d;
    logic             pick1;
    logic             last_bit;

`ifdef PARITY_CHECK_EN
    logic             exp_q, exp_d;
`else
    logic             unused_exp_par;
    assign unused_exp_par = exp_par0 ^ exp_par1;
`endif

    // On a tie the requester that did not own the previous frame wins.
    assign pick1    = req1 & (~req0 | ~last_owner_q);
    assign last_bit = (bitcnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        par_d        = par_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        busy_d       = busy_q;
        x_d          = 1'b0;
        done_d       = 1'b0;
        parity_d     = parity_q;
        err_d        = err_q;
`ifdef PARITY_CHECK_EN
        exp_d        = exp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    state_d      = ST_SHIFT;
                    shreg_d      = pick1 ? data1 : data0;
                    bitcnt_d     = '0;
                    par_d        = 1'b0;
                    owner_d      = pick1;
                    last_owner_d = pick1;
                    gnt0_d       = ~pick1;
                    gnt1_d       = pick1;
                    busy_d       = 1'b1;
                    x_d          = shreg_d[0];
                    parity_d     = 1'b0;
                    err_d        = 1'b0;
`ifdef PARITY_CHECK_EN
                    exp_d        = pick1 ? exp_par1 : exp_par0;
`endif
                end
            end
            ST_SHIFT: begin
                par_d    = par_q ^ shreg_q[0];
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + CW'(1);
                if (last_bit) begin
`ifdef PARITY_CHECK_EN
                    state_d = ST_CHECK;
                    x_d     = exp_q;
`else
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    parity_d = par_d;
                    err_d    = 1'b0;
`endif
                end else begin
                    x_d = shreg_q[1];
                end
            end
`ifdef PARITY_CHECK_EN
            ST_CHECK: begin
                // The expected bit is on the line this cycle but does not fold into par.
                state_d  = ST_DONE;
                done_d   = 1'b1;
                parity_d = par_q;
                err_d    = par_q ^ exp_q;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            par_q        <= 1'b0;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            busy_q       <= 1'b0;
            x_q          <= 1'b0;
            done_q       <= 1'b0;
            parity_q     <= 1'b0;
            err_q        <= 1'b0;
`ifdef PARITY_CHECK_EN
            exp_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            par_q        <= par_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            busy_q       <= busy_d;
            x_q          <= x_d;
            done_q       <= done_d;
            parity_q     <= parity_d;
            err_q        <= err_d;
`ifdef PARITY_CHECK_EN
            exp_q        <= exp_d;
`endif
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    assign x      = x_q;
    assign z      = par_q;
    assign done   = done_q;
    assign parity = parity_q;
    assign err    = err_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Randomized scoreboard bench for parity_frame_ctrl; the stimulus side predicts arbitration and frame contents,
// a negedge monitor pops predictions at each grant and checks the serial stream, latency and final parity.
module tb_parity_frame_ctrl;
    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int NB     = W + 1;
    localparam bit CHK_EN = 1'b1;
`else
    localparam int NB     = W;
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         exp_par0, exp_par1;
    logic         gnt0, gnt1, owner, busy, x, z, done, parity, err;

    parity_frame_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .exp_par0(exp_par0), .exp_par1(exp_par1),
        .gnt0(gnt0), .gnt1(gnt1), .owner(owner), .busy(busy),
        .x(x), .z(z), .done(done), .parity(parity), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           own;
        logic [W-1:0] dat;
        bit           ep;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;

    // Requester-side model state
    bit           last_own = 1'b1;
    bit           pend0, pend1;
    logic [W-1:0] d0, d1;
    bit           e0, e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Bit k of the line during cycle k after the grant: data LSB-first, then the expected bit.
    function automatic logic [W:0] model_x(input exp_t e);
        logic [W:0] v;
        v = '0;
        for (int k = 0; k < W; k++) v[k] = e.dat[k];
        if (CHK_EN) v[W] = e.ep;
        return v;
    endfunction

    // z during cycle k is the parity of the k bits already sent.
    function automatic logic [W:0] model_z(input exp_t e);
        logic [W:0] v;
        int ones;
        v = '0;
        ones = 0;
        for (int k = 0; k < NB; k++) begin
            v[k] = (ones % 2 == 1);
            if (k < W && e.dat[k]) ones++;
        end
        return v;
    endfunction

    function automatic bit model_par(input exp_t e);
        int ones;
        ones = 0;
        for (int k = 0; k < W; k++) if (e.dat[k]) ones++;
        return (ones % 2 == 1);
    endfunction

    // Monitor
    bit         in_frame = 1'b0;
    int         cyc = 0;
    logic [W:0] xs, zs;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                if (sb_q.size() == 0) begin
                    chk("gnt_unexpected", {gnt1, gnt0}, 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("gnt_who", {gnt1, gnt0}, cur.own ? 2 : 1);
                    chk("owner_at_gnt", owner, cur.own);
                    chk("busy_at_gnt", busy, 1);
                    in_frame = 1'b1;
                    cyc      = 0;
                    xs       = '0;
                    zs       = '0;
                end
            end
            if (in_frame) begin
                if (cyc < NB) begin
                    xs[cyc] = x;
                    zs[cyc] = z;
                end
                if (done) begin
                    chk("done_latency", cyc, NB);
                    chk("x_stream", xs, model_x(cur));
                    chk("z_stream", zs, model_z(cur));
                    chk("parity", parity, model_par(cur));
                    chk("err", err, CHK_EN ? (model_par(cur) != cur.ep) : 1'b0);
                    chk("owner_at_done", owner, cur.own);
                    chk("x_at_done", x, 0);
                    in_frame = 1'b0;
                end else if (cyc > NB) begin
                    chk("done_timeout", cyc, NB);
                    in_frame = 1'b0;
                end
                cyc++;
            end else begin
                if (done) chk("done_unexpected", done, 0);
                if (!busy) chk("x_idle", x, 0);
            end
        end
    end

    // Stimulus helpers
    task automatic set_req(input int idx, input bit v, input logic [W-1:0] d, input bit e);
        if (idx == 0) begin
            req0 = v; data0 = d; exp_par0 = e;
            pend0 = v; d0 = d; e0 = e;
        end else begin
            req1 = v; data1 = d; exp_par1 = e;
            pend1 = v; d1 = d; e1 = e;
        end
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * W + 10; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("gnt_wait", ok, 1);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * W + 10; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_wait", ok, 1);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * W + 10; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", ok, 1);
    endtask

    task automatic push_exp(input bit own, input logic [W-1:0] dat, input bit ep);
        exp_t e;
        e.own = own;
        e.dat = dat;
        e.ep  = ep;
        sb_q.push_back(e);
        last_own = own;
    endtask

    // One arbitrated frame; the winner drops its request on grant and changes its inputs mid-frame.
    task automatic run_frame(input bit rnd, input logic [W-1:0] post_dat);
        bit win;
        bit ok;
        bit old_ep;
        win    = (pend0 && pend1) ? !last_own : pend1;
        old_ep = win ? e1 : e0;
        push_exp(win, win ? d1 : d0, old_ep);
        wait_gnt(ok);
        set_req(win ? 1 : 0, 1'b0, rnd ? W'($urandom) : post_dat, rnd ? 1'($urandom) : !old_ep);
        if (rnd && $urandom_range(0, 1) == 1 && !(win ? pend0 : pend1))
            set_req(win ? 0 : 1, 1'b1, W'($urandom), 1'($urandom));
        wait_done(ok);
        wait_idle(ok);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        set_req(0, 1'b1, 8'hB5, 1'b1);
        set_req(1, 1'b1, 8'h3C, 1'b0);

        // Reset with both requests high: everything quiet
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", {gnt0, gnt1, busy, x, z, done, parity, err, owner}, 0);
        end

        // Both requests held through three frames: 0, 1, 0
        last_own = 1'b1;
        push_exp(0, 8'hB5, 1'b1);
        push_exp(1, 8'h3C, 1'b0);
        push_exp(0, 8'hB5, 1'b1);
        rst_n = 1'b1;
        wait_gnt(ok);
        wait_gnt(ok);
        wait_gnt(ok);
        set_req(0, 1'b0, 8'hB5, 1'b1);
        set_req(1, 1'b0, 8'h3C, 1'b0);
        wait_done(ok);
        wait_idle(ok);

        // Reset during bit 4 of 8'hFF aborts the frame
        set_req(0, 1'b1, 8'hFF, 1'b0);
        sb_q.push_back('{own: 1'b0, dat: 8'hFF, ep: 1'b0});
        wait_gnt(ok);
        set_req(0, 1'b0, 8'hFF, 1'b0);
        repeat (4) @(negedge clk);
        chk("x_bit4_ff", x, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy_z_done", {busy, z, done}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_own = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_quiet", {busy, done, gnt0, gnt1}, 0);

        // Next frame after the abort completes normally, data changed after grant
        set_req(0, 1'b1, 8'h01, 1'b1);
        run_frame(1'b0, 8'h00);

        // Expected-parity match then mismatch on the same word
        set_req(0, 1'b1, 8'hB5, 1'b1);
        run_frame(1'b0, 8'h00);
        set_req(0, 1'b1, 8'hB5, 1'b0);
        run_frame(1'b0, 8'hFF);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!pend0 && $urandom_range(0, 2) == 0) set_req(0, 1'b1, W'($urandom), 1'($urandom));
            if (!pend1 && $urandom_range(0, 2) == 0) set_req(1, 1'b1, W'($urandom), 1'($urandom));
            if (!pend0 && !pend1) set_req(int'($urandom_range(0, 1)), 1'b1, W'($urandom), 1'($urandom));
            run_frame(1'b1, '0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
